// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one data-memory port between the instruction-fetch unit (IF, word
// reads only) and the load/store unit (LS). Each accepted request is checked
// for MemOp legality and alignment. It then either runs a memory access,
// which is bounded by a timeout, or is answered with an error immediately.
// Exactly one response goes back to the owning requester.
//
// Ports
//   Clk, Rst_n                   clock (rising edge), async active-low reset
//   IfReqValid/IfReqReady/IfAddr IF request handshake and byte address
//   IfRspValid/IfRspData/IfRspErr IF one-cycle response
//   LsReqValid/LsReqReady/LsAddr/LsMemWr/LsMemOp/LsWData  LS request
//   LsRspValid/LsRspData/LsRspErr LS one-cycle response
//   MemReq/MemAddr/MemWr/MemOp/MemWData  registered memory request
//   MemAck/MemRData              memory completion and read data
//
// state | meaning
// IDLE  | arbitrate and accept one request
// BUSY  | memory access in flight, waiting for MemAck or timeout
// RESP  | one-cycle response strobe to the owner
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        IfReqValid,
    output logic        IfReqReady,
    input  logic [31:0] IfAddr,
    output logic        IfRspValid,
    output logic [31:0] IfRspData,
    output logic        IfRspErr,
    input  logic        LsReqValid,
    output logic        LsReqReady,
    input  logic [31:0] LsAddr,
    input  logic        LsMemWr,
    input  logic [2:0]  LsMemOp,
    input  logic [31:0] LsWData,
    output logic        LsRspValid,
    output logic [31:0] LsRspData,
    output logic        LsRspErr,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    output logic        MemWr,
    output logic [2:0]  MemOp,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [31:0]       addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic        idle;
    logic        grant_ls;
    logic        grant_if;
    logic        handshake;
    logic [31:0] req_addr;
    logic [2:0]  req_op;
    logic        req_wr;
    logic [31:0] req_wdata;
    logic        req_legal;
    logic        timeout_hit;

    function automatic logic is_legal(input logic [2:0] op, input logic [1:0] ofs);
        logic ok;
        case (op)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = (ofs != 2'b11);
            3'b010:         ok = (ofs == 2'b00);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Ready is gated by Rst_n so that every output is low while reset is held.
    assign idle      = (state_q == S_IDLE) && Rst_n;
    // On a tie, LS wins only if IF was granted last (round-robin).
    assign grant_ls  = LsReqValid && (!IfReqValid || (last_grant_q == OWN_IF));
    assign grant_if  = IfReqValid && !grant_ls;
    assign handshake = idle && (grant_if || grant_ls);

    // IF requests are always word reads.
    assign req_addr  = grant_ls ? LsAddr : IfAddr;
    assign req_op    = grant_ls ? LsMemOp : 3'b010;
    assign req_wr    = grant_ls && LsMemWr;
    assign req_wdata = grant_ls ? LsWData : 32'h0;
    assign req_legal = is_legal(req_op, req_addr[1:0]);

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_LS;
            addr_q       <= 32'h0;
            wr_q         <= 1'b0;
            op_q         <= 3'b000;
            wdata_q      <= 32'h0;
            cnt_q        <= '0;
            rsp_data_q   <= 32'h0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            op_q         <= op_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        op_d         = op_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    owner_d      = grant_ls;
                    last_grant_d = grant_ls;
                    addr_d       = req_addr;
                    wr_d         = req_wr;
                    op_d         = req_op;
                    wdata_d      = req_wdata;
                    rsp_data_d   = 32'h0;
                    rsp_err_d    = !req_legal;
                    state_d      = req_legal ? S_BUSY : S_RESP;
                end
            end
            S_BUSY: begin
                if (MemAck) begin
                    rsp_data_d = wr_q ? 32'h0 : MemRData;
                    rsp_err_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_RESP;
                end else if (timeout_hit) begin
                    rsp_data_d = 32'h0;
                    rsp_err_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        IfReqReady = idle && grant_if;
        LsReqReady = idle && grant_ls;
        MemReq     = (state_q == S_BUSY);
        MemAddr    = MemReq ? addr_q  : 32'h0;
        MemWr      = MemReq && wr_q;
        MemOp      = MemReq ? op_q    : 3'b000;
        MemWData   = MemReq ? wdata_q : 32'h0;
        IfRspValid = (state_q == S_RESP) && (owner_q == OWN_IF);
        LsRspValid = (state_q == S_RESP) && (owner_q == OWN_LS);
        IfRspData  = IfRspValid ? rsp_data_q : 32'h0;
        IfRspErr   = IfRspValid && rsp_err_q;
        LsRspData  = LsRspValid ? rsp_data_q : 32'h0;
        LsRspErr   = LsRspValid && rsp_err_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Instance a_ uses TIMEOUT=4 and instance
// b_ uses the default TIMEOUT=255. Both instances are driven by the same inputs.
module tb_mem_port_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        IfReqValid = 1'b0;
    logic [31:0] IfAddr = 32'h0;
    logic        LsReqValid = 1'b0;
    logic [31:0] LsAddr = 32'h0;
    logic        LsMemWr = 1'b0;
    logic [2:0]  LsMemOp = 3'b000;
    logic [31:0] LsWData = 32'h0;
    logic        MemAck = 1'b0;
    logic [31:0] MemRData = 32'h0;

    logic        a_IfReqReady, a_IfRspValid, a_IfRspErr;
    logic        a_LsReqReady, a_LsRspValid, a_LsRspErr;
    logic [31:0] a_IfRspData, a_LsRspData, a_MemAddr, a_MemWData;
    logic        a_MemReq, a_MemWr;
    logic [2:0]  a_MemOp;
    logic        b_IfReqReady, b_IfRspValid, b_IfRspErr;
    logic        b_LsReqReady, b_LsRspValid, b_LsRspErr;
    logic [31:0] b_IfRspData, b_LsRspData, b_MemAddr, b_MemWData;
    logic        b_MemReq, b_MemWr;
    logic [2:0]  b_MemOp;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .IfReqValid(IfReqValid), .IfReqReady(a_IfReqReady), .IfAddr(IfAddr),
        .IfRspValid(a_IfRspValid), .IfRspData(a_IfRspData), .IfRspErr(a_IfRspErr),
        .LsReqValid(LsReqValid), .LsReqReady(a_LsReqReady), .LsAddr(LsAddr),
        .LsMemWr(LsMemWr), .LsMemOp(LsMemOp), .LsWData(LsWData),
        .LsRspValid(a_LsRspValid), .LsRspData(a_LsRspData), .LsRspErr(a_LsRspErr),
        .MemReq(a_MemReq), .MemAddr(a_MemAddr), .MemWr(a_MemWr), .MemOp(a_MemOp),
        .MemWData(a_MemWData), .MemAck(MemAck), .MemRData(MemRData)
    );

    mem_port_arbiter dut_l (
        .Clk(Clk), .Rst_n(Rst_n),
        .IfReqValid(IfReqValid), .IfReqReady(b_IfReqReady), .IfAddr(IfAddr),
        .IfRspValid(b_IfRspValid), .IfRspData(b_IfRspData), .IfRspErr(b_IfRspErr),
        .LsReqValid(LsReqValid), .LsReqReady(b_LsReqReady), .LsAddr(LsAddr),
        .LsMemWr(LsMemWr), .LsMemOp(LsMemOp), .LsWData(LsWData),
        .LsRspValid(b_LsRspValid), .LsRspData(b_LsRspData), .LsRspErr(b_LsRspErr),
        .MemReq(b_MemReq), .MemAddr(b_MemAddr), .MemWr(b_MemWr), .MemOp(b_MemOp),
        .MemWData(b_MemWData), .MemAck(MemAck), .MemRData(MemRData)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic smp();
        @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ls_illegal(input logic [2:0] op, input logic [31:0] addr, input string tag);
        LsReqValid = 1'b1; LsMemWr = 1'b0; LsMemOp = op; LsAddr = addr;
        smp();
        chk({tag, "_ready"}, a_LsReqReady, 1);
        tick();
        LsReqValid = 1'b0;
        smp();
        chk({tag, "_memreq"}, a_MemReq, 0);
        chk({tag, "_rspvalid"}, a_LsRspValid, 1);
        chk({tag, "_rsperr"}, a_LsRspErr, 1);
        chk({tag, "_rspdata"}, a_LsRspData, 0);
        tick();
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        smp();
        chk("rst_memreq", a_MemReq, 0);
        chk("rst_ifready", a_IfReqReady, 0);
        chk("rst_lsrsp", a_LsRspValid, 0);
        chk("rst_memaddr", a_MemAddr, 0);
        chk("rst_b_memreq", b_MemReq, 0);
        tick();
        Rst_n = 1'b1;

        // IF-only word fetch, ack in the first BUSY cycle
        IfReqValid = 1'b1; IfAddr = 32'h8000_0004;
        smp();
        chk("s1_ifready", a_IfReqReady, 1);
        chk("s1_lsready", a_LsReqReady, 0);
        chk("s1_memreq_idle", a_MemReq, 0);
        tick();
        IfReqValid = 1'b0; MemAck = 1'b1; MemRData = 32'h0000_0413;
        smp();
        chk("s1_memreq", a_MemReq, 1);
        chk("s1_memop", a_MemOp, 3'b010);
        chk("s1_memwr", a_MemWr, 0);
        chk("s1_memaddr", a_MemAddr, 32'h8000_0004);
        tick();
        MemAck = 1'b0; MemRData = 32'h0;
        smp();
        chk("s1_rspvalid", a_IfRspValid, 1);
        chk("s1_rspdata", a_IfRspData, 32'h0000_0413);
        chk("s1_rsperr", a_IfRspErr, 0);
        chk("s1_ls_rspvalid", a_LsRspValid, 0);
        chk("s1_memreq_resp", a_MemReq, 0);
        chk("s1_b_rspdata", b_IfRspData, 32'h0000_0413);
        tick();
        smp();
        chk("s1_rspvalid_after", a_IfRspValid, 0);
        chk("s1_rspdata_after", a_IfRspData, 0);

        // Reset so last_grant is LS again and IF wins the first tie
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;

        // Simultaneous IF+LS held for two accesses
        IfReqValid = 1'b1; IfAddr = 32'h8000_0008;
        LsReqValid = 1'b1; LsAddr = 32'h8000_1002; LsMemWr = 1'b1;
        LsMemOp = 3'b001; LsWData = 32'h0000_BEEF;
        smp();
        chk("s2_ifready", a_IfReqReady, 1);
        chk("s2_lsready", a_LsReqReady, 0);
        tick();
        MemAck = 1'b1; MemRData = 32'h1234_5678;
        smp();
        chk("s2_if_memaddr", a_MemAddr, 32'h8000_0008);
        chk("s2_if_memop", a_MemOp, 3'b010);
        chk("s2_if_memwr", a_MemWr, 0);
        chk("s2_busy_lsready", a_LsReqReady, 0);
        tick();
        MemAck = 1'b0;
        smp();
        chk("s2_if_rspvalid", a_IfRspValid, 1);
        chk("s2_if_rspdata", a_IfRspData, 32'h1234_5678);
        chk("s2_resp_ifready", a_IfReqReady, 0);
        chk("s2_resp_lsready", a_LsReqReady, 0);
        tick();
        smp();
        chk("s2_rr_lsready", a_LsReqReady, 1);
        chk("s2_rr_ifready", a_IfReqReady, 0);
        tick();
        IfReqValid = 1'b0; LsReqValid = 1'b0;
        MemAck = 1'b1; MemRData = 32'hFFFF_FFFF;
        smp();
        chk("s2_ls_memaddr", a_MemAddr, 32'h8000_1002);
        chk("s2_ls_memwr", a_MemWr, 1);
        chk("s2_ls_memop", a_MemOp, 3'b001);
        chk("s2_ls_memwdata", a_MemWData, 32'h0000_BEEF);
        tick();
        MemAck = 1'b0; MemRData = 32'h0;
        smp();
        chk("s2_ls_rspvalid", a_LsRspValid, 1);
        chk("s2_ls_rspdata", a_LsRspData, 0);
        chk("s2_ls_rsperr", a_LsRspErr, 0);
        chk("s2_ls_if_rspvalid", a_IfRspValid, 0);
        tick();
        LsMemWr = 1'b0; LsWData = 32'h0;

        // Illegal requests: error response one cycle after handshake
        ls_illegal(3'b010, 32'h8000_1001, "s3_word_mis");
        ls_illegal(3'b011, 32'h8000_1000, "s3_op011");
        ls_illegal(3'b101, 32'h8000_1003, "s3_lhu_ofs3");

        // Legal boundary: lhu at offset 1 goes to memory
        LsReqValid = 1'b1; LsMemOp = 3'b101; LsAddr = 32'h8000_1001;
        smp();
        chk("s3b_ready", a_LsReqReady, 1);
        tick();
        LsReqValid = 1'b0; MemAck = 1'b1; MemRData = 32'h0000_FFEE;
        smp();
        chk("s3b_memreq", a_MemReq, 1);
        chk("s3b_memop", a_MemOp, 3'b101);
        chk("s3b_memaddr", a_MemAddr, 32'h8000_1001);
        tick();
        MemAck = 1'b0; MemRData = 32'h0;
        smp();
        chk("s3b_rspvalid", a_LsRspValid, 1);
        chk("s3b_rspdata", a_LsRspData, 32'h0000_FFEE);
        chk("s3b_rsperr", a_LsRspErr, 0);
        tick();

        // Timeout on instance a_ (TIMEOUT=4): byte load, MemAck never comes
        LsReqValid = 1'b1; LsMemOp = 3'b000; LsAddr = 32'h8000_2003;
        smp();
        chk("s4_ready", a_LsReqReady, 1);
        tick();
        LsReqValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk($sformatf("s4_memreq_c%0d", i), a_MemReq, 1);
            tick();
        end
        smp();
        chk("s4_memreq_drop", a_MemReq, 0);
        chk("s4_rspvalid", a_LsRspValid, 1);
        chk("s4_rsperr", a_LsRspErr, 1);
        chk("s4_rspdata", a_LsRspData, 0);
        chk("s4_b_still_busy", b_MemReq, 1);
        tick();

        // Reset during BUSY on a_ (b_ still waiting on the previous access)
        IfReqValid = 1'b1; IfAddr = 32'h8000_0010;
        smp();
        chk("s6_ifready", a_IfReqReady, 1);
        tick();
        IfReqValid = 1'b0;
        #1;
        chk("s6_busy_memreq", a_MemReq, 1);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("s6_rst_memreq", a_MemReq, 0);
        chk("s6_rst_b_memreq", b_MemReq, 0);
        tick();
        Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk($sformatf("s6_no_ifrsp_c%0d", i), a_IfRspValid, 0);
            chk($sformatf("s6_no_b_lsrsp_c%0d", i), b_LsRspValid, 0);
            tick();
        end
        IfReqValid = 1'b1; IfAddr = 32'h8000_0014;
        smp();
        chk("s6_post_ifready", a_IfReqReady, 1);
        tick();
        IfReqValid = 1'b0; MemAck = 1'b1; MemRData = 32'hCAFE_0001;
        smp();
        chk("s6_post_memreq", a_MemReq, 1);
        chk("s6_post_memaddr", a_MemAddr, 32'h8000_0014);
        tick();
        MemAck = 1'b0; MemRData = 32'h0;
        smp();
        chk("s6_post_rspvalid", a_IfRspValid, 1);
        chk("s6_post_rspdata", a_IfRspData, 32'hCAFE_0001);
        tick();

        // MemAck delayed 10 cycles on instance b_ (TIMEOUT=255)
        LsReqValid = 1'b1; LsMemOp = 3'b100; LsAddr = 32'h8000_3000; LsMemWr = 1'b0;
        smp();
        chk("s5_ready", b_LsReqReady, 1);
        tick();
        LsReqValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                MemAck = 1'b1; MemRData = 32'h0000_00A5;
            end
            smp();
            chk($sformatf("s5_memreq_c%0d", i), b_MemReq, 1);
            chk($sformatf("s5_memaddr_c%0d", i), b_MemAddr, 32'h8000_3000);
            chk($sformatf("s5_memop_c%0d", i), b_MemOp, 3'b100);
            chk($sformatf("s5_memwr_c%0d", i), b_MemWr, 0);
            chk($sformatf("s5_no_rsp_c%0d", i), b_LsRspValid, 0);
            tick();
        end
        MemAck = 1'b0; MemRData = 32'h0;
        smp();
        chk("s5_rspvalid", b_LsRspValid, 1);
        chk("s5_rspdata", b_LsRspData, 32'h0000_00A5);
        chk("s5_rsperr", b_LsRspErr, 0);
        chk("s5_memreq_drop", b_MemReq, 0);
        tick();

        // Stray MemAck in IDLE
        MemAck = 1'b1; MemRData = 32'h0000_0055;
        smp();
        chk("s7_memreq", b_MemReq, 0);
        chk("s7_ls_rsp", b_LsRspValid, 0);
        tick();
        MemAck = 1'b0; MemRData = 32'h0;
        smp();
        chk("s7_b_ls_rsp_next", b_LsRspValid, 0);
        chk("s7_b_if_rsp_next", b_IfRspValid, 0);
        chk("s7_a_ls_rsp_next", a_LsRspValid, 0);
        chk("s7_a_ls_data_next", a_LsRspData, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
